match_point_sweeper: RTL and testbench
======================================

MATCH_POINT_SWEEPER -- requirements
Module: match_point_sweeper

Interface
REQ-001 Parameter LAT, 14, fixed latency in clocks from alpha_o change to the matching point-set result on the pt_* inputs.
REQ-002 Parameter DEPTH, 16, result FIFO depth in entries (power of two, 4..64).
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that begins a sweep.
REQ-006 alpha_start  in  12  first alpha, sampled on start.
REQ-007 alpha_step  in  12  alpha increment, sampled on start.
REQ-008 n_steps  in  6  number of alphas to issue (0..32), sampled on start.
REQ-009 alpha_o  out  12  alpha driven to the matching point calculator.
REQ-010 pt_xi, pt_yi, pt_xo, pt_yo  in  56 each  four packed 14-bit points from the calculator, point 0 in bits [13:0].
REQ-011 pt_xb, pt_yb  in  14 each  boundary point from the calculator.
REQ-012 out_data  out  252  {pt_yb, pt_xb, pt_yo, pt_xo, pt_yi, pt_xi} for one alpha.
REQ-013 out_alpha  out  12  alpha belonging to out_data (see Configuration).
REQ-014 out_valid  out  1  FIFO head valid; out_ready  in  1  consumer accepts.
REQ-015 busy  out  1  sweep in progress; done  out  1  one-cycle pulse when the last result is in the FIFO.

Function
REQ-016 States IDLE, SWEEP, DRAIN, DONE; IDLE->SWEEP on start with n_steps>0; IDLE->DONE on start with n_steps=0.
REQ-017 SWEEP: one alpha issued per cycle when in_flight + fifo_count < DEPTH; otherwise alpha_o holds and no issue occurs (credit stall).
REQ-018 First issue: alpha_o = alpha_start in the cycle after start; each later issue adds alpha_step modulo 4096 (12-bit wrap, no saturation).
REQ-019 SWEEP->DRAIN in the cycle after the n_steps-th issue; DRAIN->DONE when in_flight reaches 0; DONE->IDLE after one cycle, done=1 in DONE only.
REQ-020 Issue tag travels a LAT-stage shift register with its alpha; at tag exit, pt_* sampled at that edge are pushed into the FIFO; out_valid no earlier than LAT+1 cycles after the issue.
REQ-021 FIFO pops on out_valid & out_ready; simultaneous push and pop in the same cycle allowed, count unchanged; order strictly preserved.
REQ-022 Credit rule guarantees no push when full; push-when-full is unreachable and shall be asserted in simulation.
REQ-023 start while busy=1 is ignored; out_ready ignored when out_valid=0.
REQ-024 busy=1 in SWEEP and DRAIN; FIFO contents may remain after DONE until popped; new start allowed with FIFO non-empty.

Reset
REQ-025 rst=1 immediately forces state IDLE, alpha_o=0, busy=0, done=0, out_valid=0, out_data=0, out_alpha=0, FIFO empty, shift tags cleared.
REQ-026 Reset mid-sweep discards all in-flight and buffered results; no output appears after release until a new start.

Configuration
REQ-027 Macro ALPHA_TAG_EN defined: alpha travels with each tag and is stored per FIFO entry, out_alpha valid with out_data.
REQ-028 ALPHA_TAG_EN undefined: no alpha storage, out_alpha tied to 0; all other behaviour identical.

Verification
REQ-029 alpha_start=0, step=200, n=18, out_ready=1 -> 18 results in order, out_alpha 0,200,...,3400, done once, first out_valid LAT+2 cycles after start.
REQ-030 alpha_start=4000, step=200, n=3 -> alpha_o 4000, 104, 304 (wrap).
REQ-031 n=32, out_ready=0 -> exactly 16 issues then stall, FIFO full, out_valid=1; raise out_ready -> all 32 results in order, none lost or duplicated.
REQ-032 n=0 -> done pulse in the cycle after start's state transition, no issue, no output.
REQ-033 rst asserted during SWEEP at issue 5 of 18 -> all outputs zero at once; after release no out_valid until next start.
REQ-034 start pulsed again during SWEEP -> ignored, sweep count and alpha sequence unchanged.

Source files
------------

// File: rtl/match_point_sweeper.sv
// Sweeps alpha through the matching point calculator and buffers the point sets in order.
// Optional feature macro: ALPHA_TAG_EN (alpha stored with each result on out_alpha).
module match_point_sweeper #(
    parameter int LAT   = 14,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [11:0]  alpha_start,
    input  logic [11:0]  alpha_step,
    input  logic [5:0]   n_steps,
    output logic [11:0]  alpha_o,
    input  logic [55:0]  pt_xi,
    input  logic [55:0]  pt_yi,
    input  logic [55:0]  pt_xo,
    input  logic [55:0]  pt_yo,
    input  logic [13:0]  pt_xb,
    input  logic [13:0]  pt_yb,
    output logic [251:0] out_data,
    output logic [11:0]  out_alpha,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [11:0]     step;
    logic [5:0]      remaining;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   in_flight_nxt;
    logic [CW-1:0]   count;
    logic [SW-1:0]   credit_sum;
    logic [LAT-1:0]  tag;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [251:0]    mem [DEPTH];
    logic            issue;
    logic            push;
    logic            pop;

    // Results still in the calculator pipe count against FIFO space,
    // so an issued alpha always has a slot waiting for it.
    assign credit_sum    = SW'(in_flight) + SW'(count);
    assign issue         = (state == SWEEP) && (credit_sum < SW'(DEPTH));
    assign push          = tag[LAT-1];
    assign out_valid     = (count != '0);
    assign pop           = out_valid && out_ready;
    assign in_flight_nxt = in_flight + CW'(issue) - CW'(push);
    assign out_data      = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alpha_o   <= '0;
            step      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (n_steps != '0) begin
                            state     <= SWEEP;
                            busy      <= 1'b1;
                            alpha_o   <= alpha_start;
                            step      <= alpha_step;
                            remaining <= n_steps;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (issue) begin
                        remaining <= remaining - 6'd1;
                        if (remaining == 6'd1) begin
                            state <= DRAIN;
                        end else begin
                            alpha_o <= alpha_o + step;
                        end
                    end
                end
                DRAIN: begin
                    if (in_flight_nxt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag       <= '0;
            in_flight <= '0;
        end else begin
            tag       <= (tag << 1) | LAT'(issue);
            in_flight <= in_flight_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pt_yb, pt_xb, pt_yo, pt_xo, pt_yi, pt_xi};
    end

`ifdef ALPHA_TAG_EN
    logic [11:0] alpha_sr [LAT];
    logic [11:0] amem [DEPTH];

    always_ff @(posedge clk) begin
        alpha_sr[0] <= alpha_o;
        for (int i = 1; i < LAT; i++) alpha_sr[i] <= alpha_sr[i-1];
        if (push) amem[wr_ptr] <= alpha_sr[LAT-1];
    end

    assign out_alpha = out_valid ? amem[rd_ptr] : '0;
`else
    assign out_alpha = '0;
`endif

    // The credit scheme makes this unreachable; catch it if that ever breaks.
    assert property (@(posedge clk) disable iff (rst)
        !(push && count == CW'(DEPTH)));

endmodule

// File: tb/tb_match_point_sweeper.sv
// Directed bench for match_point_sweeper with a fixed-latency calculator model.
module tb_match_point_sweeper;

    localparam int LAT   = 14;
    localparam int DEPTH = 16;

    typedef struct {
        logic [11:0] a0;
        logic [11:0] step;
        logic [5:0]  n;
        logic [11:0] last;
        bit          restart;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [11:0]  alpha_start;
    logic [11:0]  alpha_step;
    logic [5:0]   n_steps;
    logic [11:0]  alpha_o;
    logic [55:0]  pt_xi, pt_yi, pt_xo, pt_yo;
    logic [13:0]  pt_xb, pt_yb;
    logic [251:0] out_data;
    logic [11:0]  out_alpha;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    match_point_sweeper #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .alpha_start(alpha_start), .alpha_step(alpha_step),
        .n_steps(n_steps), .alpha_o(alpha_o),
        .pt_xi(pt_xi), .pt_yi(pt_yi), .pt_xo(pt_xo), .pt_yo(pt_yo),
        .pt_xb(pt_xb), .pt_yb(pt_yb),
        .out_data(out_data), .out_alpha(out_alpha),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [251:0] pts(input logic [11:0] a);
        logic [251:0] d;
        d = '0;
        for (int j = 0; j < 18; j++)
            d[j*14 +: 14] = 14'({2'b00, a}) + 14'(j * 613 + 1);
        return d;
    endfunction

    // Calculator model: pt_* in cycle c reflect alpha_o of cycle c-LAT.
    logic [11:0]  hist [LAT];
    logic [251:0] calc;

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= alpha_o;
    end

    assign calc  = pts(hist[LAT-1]);
    assign pt_xi = calc[55:0];
    assign pt_yi = calc[111:56];
    assign pt_xo = calc[167:112];
    assign pt_yo = calc[223:168];
    assign pt_xb = calc[237:224];
    assign pt_yb = calc[251:238];

    task automatic chk(input string name, input logic [251:0] got,
                       input logic [251:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_alpha(input logic [11:0] got, input logic [11:0] a);
`ifdef ALPHA_TAG_EN
        chk("out_alpha", got, a);
`else
        chk("out_alpha", got, 12'd0);
`endif
    endtask

    task automatic run_sweep(input vec_t v);
        logic [11:0]  ea [64];
        logic [251:0] last_d;
        int got_n, done_n, first_cyc, total;
        ea[0] = v.a0;
        for (int k = 1; k < 64; k++) ea[k] = ea[k-1] + v.step;
        @(negedge clk);
        alpha_start = v.a0;
        alpha_step  = v.step;
        n_steps     = v.n;
        out_ready   = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        got_n     = 0;
        done_n    = 0;
        first_cyc = -1;
        last_d    = '0;
        total     = int'(v.n) + LAT + 6;
        for (int cyc = 1; cyc <= total; cyc++) begin
            if (cyc == 1) chk("busy_sweep", busy, 1'b1);
            if (cyc <= int'(v.n)) chk("alpha_o", alpha_o, ea[cyc-1]);
            if (v.restart && cyc == 3) begin
                alpha_start = 12'd999;
                alpha_step  = 12'd5;
                n_steps     = 6'd2;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) done_n++;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (got_n < int'(v.n)) begin
                    chk("out_data", out_data, pts(ea[got_n]));
                    chk_alpha(out_alpha, ea[got_n]);
                    last_d = out_data;
                end
                got_n++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("result_count", got_n, v.n);
        chk("done_pulses", done_n, 1);
        chk("first_valid_latency", first_cyc, LAT + 2);
        chk("last_result", last_d, pts(v.last));
        chk("busy_after", busy, 1'b0);
        chk("drained", out_valid, 1'b0);
    endtask

    vec_t tbl [6];

    initial begin
        logic [11:0] ea [64];
        logic [11:0] prev;
        int got_n, done_n, valid_n, busy_n;

        tbl[0] = '{a0: 12'd0,    step: 12'd200,  n: 6'd18, last: 12'd3400, restart: 1'b0};
        tbl[1] = '{a0: 12'd4000, step: 12'd200,  n: 6'd3,  last: 12'd304,  restart: 1'b0};
        tbl[2] = '{a0: 12'd100,  step: 12'd7,    n: 6'd10, last: 12'd163,  restart: 1'b1};
        tbl[3] = '{a0: 12'd4095, step: 12'd1,    n: 6'd5,  last: 12'd3,    restart: 1'b0};
        tbl[4] = '{a0: 12'd1234, step: 12'd0,    n: 6'd1,  last: 12'd1234, restart: 1'b0};
        tbl[5] = '{a0: 12'd10,   step: 12'd4095, n: 6'd16, last: 12'd4091, restart: 1'b0};

        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        alpha_start = '0; alpha_step = '0; n_steps = '0;
        repeat (2) @(negedge clk);
        chk("rst_alpha_o", alpha_o, 12'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_alpha", out_alpha, 12'd0);
        rst = 1'b0;

        foreach (tbl[i]) run_sweep(tbl[i]);

        // Zero-length sweep: straight to DONE, nothing issued.
        prev = alpha_o;
        @(negedge clk);
        alpha_start = 12'd500; n_steps = 6'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("n0_done", done, 1'b1);
        chk("n0_busy", busy, 1'b0);
        done_n = 0; valid_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) done_n++;
            if (out_valid) valid_n++;
        end
        chk("n0_extra_done", done_n, 0);
        chk("n0_no_output", valid_n, 0);
        chk("n0_alpha_hold", alpha_o, prev);

        // Full sweep against a stalled consumer.
        ea[0] = 12'd50;
        for (int k = 1; k < 64; k++) ea[k] = ea[k-1] + 12'd100;
        out_ready = 1'b0;
        alpha_start = 12'd50; alpha_step = 12'd100; n_steps = 6'd32;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc <= 16) chk("stall_alpha_o", alpha_o, ea[cyc-1]);
            if (cyc < 40) @(negedge clk);
        end
        chk("stall_alpha_hold", alpha_o, ea[16]);
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_busy", busy, 1'b1);
        chk("stall_head", out_data, pts(ea[0]));
        out_ready = 1'b1;
        got_n = 0; done_n = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done) done_n++;
            if (out_valid) begin
                if (got_n < 32) begin
                    chk("stall_data", out_data, pts(ea[got_n]));
                    chk_alpha(out_alpha, ea[got_n]);
                end
                got_n++;
            end
            @(negedge clk);
        end
        chk("stall_count", got_n, 32);
        chk("stall_done", done_n, 1);
        chk("stall_drained", out_valid, 1'b0);

        // Reset in the middle of a sweep.
        ea[0] = 12'd0;
        for (int k = 1; k < 64; k++) ea[k] = ea[k-1] + 12'd200;
        alpha_start = 12'd0; alpha_step = 12'd200; n_steps = 6'd18;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_alpha_o", alpha_o, ea[4]);
        rst = 1'b1;
        #1;
        chk("mid_rst_alpha_o", alpha_o, 12'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_alpha", out_alpha, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        valid_n = 0; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) valid_n++;
            if (busy) busy_n++;
        end
        chk("post_rst_no_valid", valid_n, 0);
        chk("post_rst_idle", busy_n, 0);

        run_sweep(tbl[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
